// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Dual-issue stage. Checks register hazards against a scoreboard,
//               arbitrates the shared multiplier and memory port, issues 0/1/2
//               instructions in program order and holds them in per-lane
//               execute latches.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int NUM_REGS = 16,
    parameter int MUL_LAT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slot0_valid,
    input  logic [15:0] slot0_instr,
    input  logic        slot1_valid,
    input  logic [15:0] slot1_instr,
    input  logic        is_branch_taken,
    input  logic        wb0_valid,
    input  logic [3:0]  wb0_rd,
    input  logic        wb1_valid,
    input  logic [3:0]  wb1_rd,
    output logic        issue0,
    output logic        issue1,
    output logic        stall,
    output logic        ex0_valid,
    output logic [15:0] ex0_instr,
    output logic        ex1_valid,
    output logic [15:0] ex1_instr,
    output logic        mul_busy
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_LSL  = 4'hB;
    localparam logic [3:0] OP_JUMP = 4'hC;
    localparam logic [3:0] OP_LSR  = 4'hD;
    localparam logic [3:0] OP_BEQ  = 4'hE;
    localparam logic [3:0] OP_BGT  = 4'hF;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT);

    // ------------------------------------------------------------------------
    // Opcode classification helpers
    // ------------------------------------------------------------------------
    function automatic logic uses_rs1(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_OR, OP_AND, OP_LSL, OP_LSR,
            OP_MOV, OP_NOT, OP_LD, OP_ST: uses_rs1 = 1'b1;
            default:                      uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_OR, OP_AND, OP_LSL, OP_LSR:
                     uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    endfunction

    // Store reads its data register through the rd field
    function automatic logic reads_rd(input logic [3:0] op);
        reads_rd = (op == OP_ST);
    endfunction

    function automatic logic is_writer(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_LD, OP_MOV, OP_OR, OP_AND, OP_NOT,
            OP_LSL, OP_LSR: is_writer = 1'b1;
            default:        is_writer = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        is_mem = (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        is_branch = (op == OP_JUMP) || (op == OP_BEQ) || (op == OP_BGT);
    endfunction

    function automatic logic is_cond_branch(input logic [3:0] op);
        is_cond_branch = (op == OP_BEQ) || (op == OP_BGT);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_REGS-1:0] scoreboard_q, scoreboard_d;
    logic [3:0]          mul_cnt_q, mul_cnt_d;
    logic                ex0_valid_q, ex1_valid_q;
    logic [15:0]         ex0_instr_q, ex1_instr_q;

    // ------------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------------
    logic [3:0] op0, rd0, rs1_0, rs2_0;
    logic [3:0] op1, rd1, rs1_1, rs2_1;

    assign op0   = slot0_instr[15:12];
    assign rd0   = slot0_instr[11:8];
    assign rs1_0 = slot0_instr[7:4];
    assign rs2_0 = slot0_instr[3:0];
    assign op1   = slot1_instr[15:12];
    assign rd1   = slot1_instr[11:8];
    assign rs1_1 = slot1_instr[7:4];
    assign rs2_1 = slot1_instr[3:0];

    logic mul_free;
    assign mul_free = (mul_cnt_q == 4'd0);

    // ------------------------------------------------------------------------
    // Hazard evaluation
    // ------------------------------------------------------------------------
    logic haz0, haz1;     // scoreboard hazards (RAW + WAW) per slot
    logic mulhaz0, mulhaz1;
    logic pair_dep;       // slot1 touches slot0's destination
    logic pair_struct;    // shared resources / control ordering between slots
    logic can0, can1;

    // Per-slot scoreboard and multiplier-occupancy checks
    always_comb begin
        haz0 = (uses_rs1(op0) && scoreboard_q[rs1_0])
            || (uses_rs2(op0) && scoreboard_q[rs2_0])
            || ((reads_rd(op0) || is_writer(op0)) && scoreboard_q[rd0]);
        haz1 = (uses_rs1(op1) && scoreboard_q[rs1_1])
            || (uses_rs2(op1) && scoreboard_q[rs2_1])
            || ((reads_rd(op1) || is_writer(op1)) && scoreboard_q[rd1]);
        mulhaz0 = (op0 == OP_MUL) && !mul_free;
        mulhaz1 = (op1 == OP_MUL) && !mul_free;
    end

    // Checks between the two slots of the same issue group
    always_comb begin
        pair_dep = 1'b0;
        if (is_writer(op0)) begin
            pair_dep = (uses_rs1(op1) && (rs1_1 == rd0))
                    || (uses_rs2(op1) && (rs2_1 == rd0))
                    || ((reads_rd(op1) || is_writer(op1)) && (rd1 == rd0));
        end
        pair_struct = ((op0 == OP_MUL) && (op1 == OP_MUL))
                   || (is_mem(op0) && is_mem(op1))
                   || is_branch(op0)
                   || ((op0 == OP_CMP) && is_cond_branch(op1));
    end

    // Issue decisions; slot1 can only go together with slot0
    always_comb begin
        can0   = slot0_valid && !is_branch_taken && !reset && !haz0 && !mulhaz0;
        can1   = can0 && slot1_valid && !haz1 && !mulhaz1
              && !pair_dep && !pair_struct;
        issue0 = can0;
        issue1 = can1;
        stall  = slot0_valid && !can0 && !is_branch_taken && !reset;
    end

    // ------------------------------------------------------------------------
    // Scoreboard next state: clear on writeback, set on issue (set wins)
    // ------------------------------------------------------------------------
    logic [NUM_REGS-1:0] sb_set, sb_clr;

    // Build per-register set/clear masks from issue and writeback
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_set[i] = (issue0 && is_writer(op0) && (rd0 == 4'(i)))
                     || (issue1 && is_writer(op1) && (rd1 == 4'(i)));
            sb_clr[i] = (wb0_valid && (wb0_rd == 4'(i)))
                     || (wb1_valid && (wb1_rd == 4'(i)));
        end
        scoreboard_d = (scoreboard_q & ~sb_clr) | sb_set;
    end

    // Multiplier occupancy: reload on MUL issue, otherwise count down to zero
    always_comb begin
        mul_cnt_d = mul_cnt_q;
        if ((issue0 && (op0 == OP_MUL)) || (issue1 && (op1 == OP_MUL))) begin
            mul_cnt_d = MUL_LOAD;
        end else if (!mul_free) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
        end
    end

    // Scoreboard and multiplier counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            scoreboard_q <= '0;
            mul_cnt_q    <= 4'd0;
        end else begin
            scoreboard_q <= scoreboard_d;
            mul_cnt_q    <= mul_cnt_d;
        end
    end

    // Execute latches: capture issued instructions, bubbles load zero
    always_ff @(posedge clk) begin
        if (reset) begin
            ex0_valid_q <= 1'b0;
            ex0_instr_q <= 16'h0000;
            ex1_valid_q <= 1'b0;
            ex1_instr_q <= 16'h0000;
        end else begin
            ex0_valid_q <= issue0;
            ex0_instr_q <= issue0 ? slot0_instr : 16'h0000;
            ex1_valid_q <= issue1;
            ex1_instr_q <= issue1 ? slot1_instr : 16'h0000;
        end
    end

    assign ex0_valid = ex0_valid_q;
    assign ex0_instr = ex0_instr_q;
    assign ex1_valid = ex1_valid_q;
    assign ex1_instr = ex1_instr_q;
    assign mul_busy  = !mul_free;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Directed plus randomized bench for dual_issue_scheduler with
//               a register-set based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset, slot0_valid, slot1_valid, is_branch_taken;
    logic [15:0] slot0_instr, slot1_instr;
    logic        wb0_valid, wb1_valid;
    logic [3:0]  wb0_rd, wb1_rd;
    logic        issue0, issue1, stall, ex0_valid, ex1_valid, mul_busy;
    logic [15:0] ex0_instr, ex1_instr;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.NUM_REGS(16), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .slot0_valid(slot0_valid), .slot0_instr(slot0_instr),
        .slot1_valid(slot1_valid), .slot1_instr(slot1_instr),
        .is_branch_taken(is_branch_taken),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
        .issue0(issue0), .issue1(issue1), .stall(stall),
        .ex0_valid(ex0_valid), .ex0_instr(ex0_instr),
        .ex1_valid(ex1_valid), .ex1_instr(ex1_instr),
        .mul_busy(mul_busy)
    );

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: pending-register set and multiplier cycles remaining
    // ------------------------------------------------------------------------
    bit [15:0] m_pend;
    int        m_mul;

    function automatic bit [15:0] reg_bit(input logic [3:0] r);
        return 16'(1) << r;
    endfunction

    function automatic bit [15:0] read_set(input logic [15:0] ins);
        case (ins[15:12])
            4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hB, 4'hD:
                return reg_bit(ins[7:4]) | reg_bit(ins[3:0]);
            4'h4, 4'h7, 4'hA: return reg_bit(ins[7:4]);
            4'h5:             return reg_bit(ins[7:4]) | reg_bit(ins[11:8]);
            default:          return 16'h0;
        endcase
    endfunction

    function automatic bit [15:0] write_set(input logic [15:0] ins);
        if (ins[15:12] inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD})
            return reg_bit(ins[11:8]);
        return 16'h0;
    endfunction

    task automatic model_issue(output bit e0, output bit e1);
        bit [15:0] t0, t1, w0;
        logic [3:0] o0, o1;
        o0 = slot0_instr[15:12];
        o1 = slot1_instr[15:12];
        t0 = read_set(slot0_instr) | write_set(slot0_instr);
        t1 = read_set(slot1_instr) | write_set(slot1_instr);
        w0 = write_set(slot0_instr);
        e0 = slot0_valid && !is_branch_taken && !reset
          && ((t0 & m_pend) == 16'h0) && !(o0 == 4'h3 && m_mul != 0);
        e1 = e0 && slot1_valid
          && ((t1 & m_pend) == 16'h0) && !(o1 == 4'h3 && m_mul != 0)
          && ((w0 & t1) == 16'h0)
          && !(o0 == 4'h3 && o1 == 4'h3)
          && !((o0 inside {4'h4, 4'h5}) && (o1 inside {4'h4, 4'h5}))
          && !(o0 inside {4'hC, 4'hE, 4'hF})
          && !(o0 == 4'h6 && (o1 inside {4'hE, 4'hF}));
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check registered outputs just after the edge.
    task automatic cycle(input string tag);
        bit e0, e1, x0v, x1v;
        bit [15:0] setm, clrm, x0i, x1i;
        @(negedge clk);
        model_issue(e0, e1);
        check({tag, ".issue0"}, issue0, e0);
        check({tag, ".issue1"}, issue1, e1);
        check({tag, ".stall"}, stall, slot0_valid && !e0 && !is_branch_taken && !reset);
        setm = (e0 ? write_set(slot0_instr) : 16'h0) | (e1 ? write_set(slot1_instr) : 16'h0);
        clrm = (wb0_valid ? reg_bit(wb0_rd) : 16'h0) | (wb1_valid ? reg_bit(wb1_rd) : 16'h0);
        x0v = e0; x1v = e1;
        x0i = e0 ? slot0_instr : 16'h0;
        x1i = e1 ? slot1_instr : 16'h0;
        if (reset) begin
            m_pend = 16'h0;
            m_mul  = 0;
        end else begin
            m_pend = (m_pend & ~clrm) | setm;
            if ((e0 && slot0_instr[15:12] == 4'h3) || (e1 && slot1_instr[15:12] == 4'h3))
                m_mul = MUL_LAT;
            else if (m_mul > 0)
                m_mul = m_mul - 1;
        end
        @(posedge clk);
        #1;
        check({tag, ".ex0_valid"}, ex0_valid, x0v);
        check({tag, ".ex0_instr"}, ex0_instr, x0i);
        check({tag, ".ex1_valid"}, ex1_valid, x1v);
        check({tag, ".ex1_instr"}, ex1_instr, x1i);
        check({tag, ".mul_busy"}, mul_busy, m_mul != 0);
        check({tag, ".scoreboard"}, dut.scoreboard_q, m_pend);
    endtask

    task automatic drive(input bit v0, input logic [15:0] i0, input bit v1, input logic [15:0] i1);
        slot0_valid = v0; slot0_instr = i0;
        slot1_valid = v1; slot1_instr = i1;
        is_branch_taken = 1'b0;
        wb0_valid = 1'b0; wb0_rd = 4'h0;
        wb1_valid = 1'b0; wb1_rd = 4'h0;
    endtask

    task automatic retire(input logic [3:0] a, input logic [3:0] b);
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        wb0_valid = 1'b1; wb0_rd = a;
        wb1_valid = 1'b1; wb1_rd = b;
        cycle("retire");
    endtask

    initial begin
        int waits, busy;
        bit [15:0] sb_before;
        m_pend = 16'h0;
        m_mul  = 0;
        reset  = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        cycle("reset");
        cycle("reset");
        reset = 1'b0;

        // Independent pair
        drive(1'b1, 16'h1123, 1'b1, 16'h2456);
        cycle("pair");
        check("pair.ex0_const", ex0_instr, 16'h1123);
        check("pair.ex1_const", ex1_instr, 16'h2456);
        check("pair.sb_const", dut.scoreboard_q, 16'h0012);
        retire(4'd1, 4'd4);

        // Intra-pair RAW: slot1 reads slot0's destination
        drive(1'b1, 16'h1123, 1'b1, 16'h2516);
        cycle("raw");
        check("raw.ex0v_const", ex0_valid, 1'b1);
        check("raw.ex1v_const", ex1_valid, 1'b0);

        // r1 still pending: MOV r5,r1 stalls until writeback of r1
        drive(1'b1, 16'h7510, 1'b0, 16'h0);
        cycle("sbstall");
        check("sbstall.stall_const", stall, 1'b1);
        cycle("sbstall");
        wb0_valid = 1'b1; wb0_rd = 4'd1;
        cycle("sbclear");
        wb0_valid = 1'b0;
        cycle("sbgo");
        check("sbgo.ex0_const", ex0_instr, 16'h7510);
        retire(4'd5, 4'd5);

        // Multiplier occupancy
        drive(1'b1, 16'h3123, 1'b0, 16'h0);
        cycle("mul1");
        busy = mul_busy ? 1 : 0;
        waits = 0;
        drive(1'b1, 16'h3456, 1'b0, 16'h0);
        for (int k = 0; k < 10; k++) begin
            cycle("mul2");
            if (ex0_valid && ex0_instr == 16'h3456) break;
            waits++;
            if (mul_busy) busy++;
        end
        check("mul.blocked_cycles", waits, 3);
        check("mul.busy_cycles", busy, 3);
        retire(4'd1, 4'd4);

        // Single memory port
        drive(1'b1, 16'h4120, 1'b1, 16'h5340);
        cycle("mem");
        check("mem.ex1v_const", ex1_valid, 1'b0);
        retire(4'd1, 4'd1);

        // CMP followed by conditional branch
        drive(1'b1, 16'h6012, 1'b1, 16'hE000);
        cycle("cmpbr");
        check("cmpbr.ex1v_const", ex1_valid, 1'b0);

        // Flush with an independent pair offered
        for (int k = 0; k < 8 && m_mul != 0; k++) begin
            drive(1'b0, 16'h0, 1'b0, 16'h0);
            cycle("drain");
        end
        drive(1'b1, 16'h1123, 1'b1, 16'h2456);
        is_branch_taken = 1'b1;
        sb_before = dut.scoreboard_q;
        cycle("flush");
        check("flush.ex0v_const", ex0_valid, 1'b0);
        check("flush.ex1v_const", ex1_valid, 1'b0);
        check("flush.sb_kept", dut.scoreboard_q, sb_before);

        // Reset in the middle of a multiply
        drive(1'b1, 16'h3789, 1'b0, 16'h0);
        cycle("rmul");
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        cycle("rmul");
        check("rmul.busy_before", mul_busy, 1'b1);
        reset = 1'b1;
        cycle("rmul_reset");
        check("rmul.busy_after", mul_busy, 1'b0);
        reset = 1'b0;

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 500; n++) begin
            logic [3:0] r;
            drive($urandom_range(0, 9) < 8, {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                                             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                  $urandom_range(0, 9) < 8, {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                                             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))});
            r = 4'($urandom_range(0, 3));
            wb0_valid = m_pend[r] && ($urandom_range(0, 1) == 1); wb0_rd = r;
            r = 4'($urandom_range(0, 3));
            wb1_valid = m_pend[r] && ($urandom_range(0, 2) == 0); wb1_rd = r;
            is_branch_taken = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
